// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
//
// Groups the three buses of the memory-access stage into one bundle:
//   request  : execute stage -> stage   (req_valid/req_ready/req_op/req_addr/
//                                        req_wdata/req_rd)
//   memory   : stage <-> data memory    (mem_addr/mem_wdata/mem_we/mem_rdata)
//   response : stage -> writeback       (resp_valid/resp_ready/resp_data/
//                                        resp_rd/resp_wen/resp_err)
//   status   : busy
//
// Handshake rule for both req and resp: a transfer happens on a rising clock
// edge where valid and ready are both 1. The sender keeps valid and all
// payload fields stable until that edge; ready may change freely.
//
// modport slave  : the lsu_mem_stage itself.
// modport master : the surroundings (execute, writeback, memory).
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if #(
  parameter int RD_W = 3
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [15:0]     req_addr;
  logic [15:0]     req_wdata;
  logic [RD_W-1:0] req_rd;

  logic [15:0]     mem_addr;
  logic [15:0]     mem_wdata;
  logic            mem_we;
  logic [15:0]     mem_rdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [15:0]     resp_data;
  logic [RD_W-1:0] resp_rd;
  logic            resp_wen;
  logic            resp_err;

  logic            busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd,
    input  mem_rdata,
    input  resp_ready,
    output req_ready,
    output mem_addr, mem_wdata, mem_we,
    output resp_valid, resp_data, resp_rd, resp_wen, resp_err,
    output busy
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd,
    output mem_rdata,
    output resp_ready,
    input  req_ready,
    input  mem_addr, mem_wdata, mem_we,
    input  resp_valid, resp_data, resp_rd, resp_wen, resp_err,
    input  busy
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//
// Memory-access pipeline stage between execute and a 16-bit, byte-addressed,
// little-endian data memory (combinational read, write on posedge when
// mem_we=1). One load/store is in flight at a time:
//
//   IDLE -> ACCESS -> RESP -> IDLE            LW, LB, SW, out-of-range
//   IDLE -> ACCESS -> WRITE -> RESP -> IDLE   SB (read-modify-write)
//
// Byte stores read the whole word in ACCESS, merge the new low byte and write
// the word back in WRITE, since the memory always writes both bytes.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      lsu_mem_stage_if.slave (request, memory and response buses, busy)
//   state_o  current FSM state (0=IDLE 1=ACCESS 2=WRITE 3=RESP), debug only
//
// Parameters:
//   ADDR_LIMIT   highest legal base address; larger addresses report resp_err
//   SIGN_EXT_LB  1: LB sign-extends bit 7, 0: LB zero-extends
//   RD_W         width of the destination-register tag
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter logic [15:0] ADDR_LIMIT  = 16'h03FE,
  parameter bit          SIGN_EXT_LB = 1'b1,
  parameter int          RD_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsu_mem_stage_if.slave       bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [15:0]     addr_q;
  logic [15:0]     wdata_q;
  logic [RD_W-1:0] rd_q;
  logic            err_q;
  logic [15:0]     merged_q;

  logic [15:0]     resp_data_q;
  logic [RD_W-1:0] resp_rd_q;
  logic            resp_wen_q;
  logic            resp_err_q;

  logic            req_fire;
  logic [15:0]     lb_ext;
  logic            in_access;
  logic            in_write;
  logic            sw_commit;

  // req_ready is gated by rst_n so nothing is offered while reset is held.
  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign req_fire      = bus.req_valid && bus.req_ready;

  assign lb_ext = SIGN_EXT_LB ? {{8{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]}
                              : {8'h00, bus.mem_rdata[7:0]};

  // ---------------------------------------------------------------------
  // FSM and all registered state/response fields.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_LW;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      rd_q        <= '0;
      err_q       <= 1'b0;
      merged_q    <= 16'h0000;
      resp_data_q <= 16'h0000;
      resp_rd_q   <= '0;
      resp_wen_q  <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rd_q    <= bus.req_rd;
            err_q   <= (bus.req_addr > ADDR_LIMIT);
            state_q <= ACCESS;
          end
        end

        ACCESS: begin
          resp_rd_q  <= rd_q;
          resp_err_q <= err_q;
          if (err_q) begin
            resp_data_q <= 16'h0000;
            resp_wen_q  <= 1'b0;
            state_q     <= RESP;
          end else begin
            case (op_q)
              OP_LW: begin
                resp_data_q <= bus.mem_rdata;
                resp_wen_q  <= 1'b1;
                state_q     <= RESP;
              end
              OP_LB: begin
                resp_data_q <= lb_ext;
                resp_wen_q  <= 1'b1;
                state_q     <= RESP;
              end
              OP_SW: begin
                // The word itself is committed by mem_we during this cycle.
                resp_data_q <= 16'h0000;
                resp_wen_q  <= 1'b0;
                state_q     <= RESP;
              end
              default: begin
                // SB: keep the memory's high byte, replace the low byte.
                merged_q    <= {bus.mem_rdata[15:8], wdata_q[7:0]};
                resp_data_q <= 16'h0000;
                resp_wen_q  <= 1'b0;
                state_q     <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          state_q <= RESP;
        end

        RESP: begin
          if (bus.resp_ready) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Memory port. Decoded only from state and captured op, so an
  // asynchronous reset (state -> IDLE) removes mem_we in the same instant
  // and a pending write never reaches the memory.
  // ---------------------------------------------------------------------
  assign in_access = (state_q == ACCESS);
  assign in_write  = (state_q == WRITE);
  assign sw_commit = in_access && (op_q == OP_SW) && !err_q;

  assign bus.mem_we    = sw_commit || in_write;
  assign bus.mem_addr  = (in_access || in_write) ? addr_q : 16'h0000;
  assign bus.mem_wdata = sw_commit ? wdata_q :
                         in_write  ? merged_q : 16'h0000;

  // ---------------------------------------------------------------------
  // Response and status outputs.
  // ---------------------------------------------------------------------
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_wen   = resp_wen_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state_q != IDLE);

  assign state_o = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
`timescale 1ns/1ps
module tb_lsu_mem_stage;

  localparam int          RD_W  = 3;
  localparam logic [15:0] LIMIT = 16'h03FE;
  localparam logic [1:0]  LW = 2'b00, SW = 2'b01, LB = 2'b10, SB = 2'b11;

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // DUTs: main (sign-extending LB) and a second one with zero-extend
  // ------------------------------------------------------------------
  lsu_mem_stage_if #(.RD_W(RD_W)) bus ();
  lsu_mem_stage_if #(.RD_W(RD_W)) zbus ();
  logic [1:0] state_dbg;
  logic [1:0] zstate_dbg;

  lsu_mem_stage #(.ADDR_LIMIT(LIMIT), .SIGN_EXT_LB(1'b1), .RD_W(RD_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .state_o(state_dbg)
  );

  lsu_mem_stage #(.ADDR_LIMIT(LIMIT), .SIGN_EXT_LB(1'b0), .RD_W(RD_W)) u_dut_zx (
    .clk(clk), .rst_n(rst_n), .bus(zbus), .state_o(zstate_dbg)
  );

  // ------------------------------------------------------------------
  // Data memory for the main DUT: 1 KiB of bytes, little-endian word port
  // ------------------------------------------------------------------
  logic [7:0] mem [1024] = '{default: 8'h00};
  logic [9:0] m_lo, m_hi;
  assign m_lo = bus.mem_addr[9:0];
  assign m_hi = m_lo + 10'd1;
  assign bus.mem_rdata = {mem[m_hi], mem[m_lo]};
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[m_lo] <= bus.mem_wdata[7:0];
      mem[m_hi] <= bus.mem_wdata[15:8];
    end
  end

  // The zero-extend DUT only performs loads; its memory is a fixed word.
  logic [15:0] zx_rdata = 16'h0000;
  assign zbus.mem_rdata = zx_rdata;

  // ------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: byte array + spec rules
  // ------------------------------------------------------------------
  logic [7:0] ref_mem [1024] = '{default: 8'h00};

  typedef struct {
    logic [15:0]     data;
    logic [RD_W-1:0] rd;
    logic            wen;
    logic            err;
    int              lat;
    int              wes;
  } resp_t;

  task automatic model(input logic [1:0] op, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [RD_W-1:0] rd,
                       output resp_t e);
    logic [9:0] lo, hi;
    logic [7:0] b;
    lo = addr[9:0];
    hi = lo + 10'd1;
    e.data = 16'h0000; e.rd = rd; e.wen = 1'b0; e.lat = 2; e.wes = 0;
    e.err = (addr > LIMIT);
    if (!e.err) begin
      case (op)
        LW: begin e.data = {ref_mem[hi], ref_mem[lo]}; e.wen = 1'b1; end
        LB: begin
          b = ref_mem[lo];
          e.data = {8'h00, b};
          if (b[7]) e.data = e.data + 16'hFF00;
          e.wen = 1'b1;
        end
        SW: begin ref_mem[lo] = wdata[7:0]; ref_mem[hi] = wdata[15:8]; e.wes = 1; end
        default: begin ref_mem[lo] = wdata[7:0]; e.wes = 1; e.lat = 3; end
      endcase
    end
  endtask

  // ------------------------------------------------------------------
  // Driver: issue one request, wait for its response, optionally stall
  // resp_ready, then complete the handshake.
  // ------------------------------------------------------------------
  task automatic run_req(input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [RD_W-1:0] rd,
                         input int stall, output resp_t r);
    int guard;
    r.data = 16'hxxxx; r.rd = 'x; r.wen = 1'bx; r.err = 1'bx; r.lat = 0; r.wes = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;
    bus.resp_ready = 1'b0;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Garbage after acceptance must be ignored.
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);
    bus.req_rd    = RD_W'($urandom);
    r.lat = 1;
    while (!bus.resp_valid && r.lat < 10) begin
      r.wes += int'(bus.mem_we);
      @(negedge clk);
      r.lat++;
    end
    if (!bus.resp_valid) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    r.data = bus.resp_data;
    r.rd   = bus.resp_rd;
    r.wen  = bus.resp_wen;
    r.err  = bus.resp_err;
    for (int i = 0; i < stall; i++) begin
      // A competing request is offered while the response is stalled.
      bus.req_valid = 1'b1;
      r.wes += int'(bus.mem_we);
      chk("stall_valid", bus.resp_valid, 1'b1);
      chk("stall_ready", bus.req_ready, 1'b0);
      chk("stall_data",  bus.resp_data, r.data);
      chk("stall_rd",    bus.resp_rd, r.rd);
      chk("stall_flags", {bus.resp_wen, bus.resp_err}, {r.wen, r.err});
      @(negedge clk);
    end
    r.wes += int'(bus.mem_we);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("after_hs_valid", bus.resp_valid, 1'b0);
    chk("after_hs_busy",  bus.busy, 1'b0);
  endtask

  task automatic cmp_resp(input string tag, input resp_t got, input resp_t exp);
    chk({tag, "_data"}, got.data, exp.data);
    chk({tag, "_rd"},   got.rd,   exp.rd);
    chk({tag, "_wen"},  got.wen,  exp.wen);
    chk({tag, "_err"},  got.err,  exp.err);
    chk({tag, "_lat"},  got.lat,  exp.lat);
    chk({tag, "_we"},   got.wes,  exp.wes);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1'b0);
    chk({tag, "_busy"},      bus.busy, 1'b0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
    chk({tag, "_resp_data"}, bus.resp_data, 16'h0000);
    chk({tag, "_resp_rd"},   bus.resp_rd, 3'd0);
    chk({tag, "_resp_flags"}, {bus.resp_wen, bus.resp_err}, 2'b00);
    chk({tag, "_mem_we"},    bus.mem_we, 1'b0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 16'h0000);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 16'h0000);
  endtask

  // ------------------------------------------------------------------
  // Directed vector table
  // ------------------------------------------------------------------
  typedef struct {
    logic [1:0]      op;
    logic [15:0]     addr;
    logic [15:0]     wdata;
    logic [RD_W-1:0] rd;
    int              stall;
    logic [15:0]     exp_data;
    logic            exp_wen;
    logic            exp_err;
  } vec_t;

  vec_t vecs [18];

  initial begin
    resp_t got, exp;
    int mism;

    bus.req_valid = 1'b0; bus.req_op = LW; bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
    bus.req_rd = '0; bus.resp_ready = 1'b0;
    zbus.req_valid = 1'b0; zbus.req_op = LW; zbus.req_addr = 16'h0; zbus.req_wdata = 16'h0;
    zbus.req_rd = '0; zbus.resp_ready = 1'b0;

    //            op  addr      wdata     rd    stall data      wen   err
    vecs[0]  = '{SW, 16'h0010, 16'hBEEF, 3'd1, 0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{LW, 16'h0010, 16'h0000, 3'd5, 0, 16'hBEEF, 1'b1, 1'b0};
    vecs[2]  = '{SW, 16'h0020, 16'h1234, 3'd2, 0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{SB, 16'h0020, 16'h00AB, 3'd3, 0, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{LW, 16'h0020, 16'h0000, 3'd4, 0, 16'h12AB, 1'b1, 1'b0};
    vecs[5]  = '{LB, 16'h0020, 16'h0000, 3'd6, 0, 16'hFFAB, 1'b1, 1'b0};
    vecs[6]  = '{LW, 16'h03FF, 16'h0000, 3'd7, 0, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{SW, 16'h0400, 16'hDEAD, 3'd1, 0, 16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{LW, 16'h0010, 16'h0000, 3'd3, 5, 16'hBEEF, 1'b1, 1'b0};
    vecs[9]  = '{SW, 16'h03FE, 16'hA55A, 3'd0, 0, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{LW, 16'h03FE, 16'h0000, 3'd2, 0, 16'hA55A, 1'b1, 1'b0};
    vecs[11] = '{LW, 16'h03FD, 16'h0000, 3'd5, 0, 16'h5A00, 1'b1, 1'b0};
    vecs[12] = '{LB, 16'h0011, 16'h0000, 3'd6, 0, 16'hFFBE, 1'b1, 1'b0};
    vecs[13] = '{SB, 16'h0011, 16'h1142, 3'd7, 2, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{LW, 16'h0010, 16'h0000, 3'd1, 0, 16'h42EF, 1'b1, 1'b0};
    vecs[15] = '{LB, 16'h0010, 16'h0000, 3'd2, 0, 16'hFFEF, 1'b1, 1'b0};
    vecs[16] = '{LB, 16'h0021, 16'h0000, 3'd3, 0, 16'h0012, 1'b1, 1'b0};
    vecs[17] = '{SB, 16'h0400, 16'h00CC, 3'd4, 0, 16'h0000, 1'b0, 1'b1};

    // ---------------- reset / idle ----------------
    #1;
    chk_all_zero("rst0");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1'b1);
    chk("idle_busy", bus.busy, 1'b0);

    // ---------------- table-driven vectors ----------------
    foreach (vecs[i]) begin
      model(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd, exp);
      run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].stall, got);
      chk($sformatf("vec%0d_data", i), got.data, vecs[i].exp_data);
      chk($sformatf("vec%0d_rd", i),   got.rd,   vecs[i].rd);
      chk($sformatf("vec%0d_wen", i),  got.wen,  vecs[i].exp_wen);
      chk($sformatf("vec%0d_err", i),  got.err,  vecs[i].exp_err);
      chk($sformatf("vec%0d_lat", i),  got.lat,  exp.lat);
      chk($sformatf("vec%0d_we", i),   got.wes,  exp.wes);
    end
    chk("mem_10", mem[10'h010], 8'hEF);
    chk("mem_11", mem[10'h011], 8'h42);
    chk("mem_20", mem[10'h020], 8'hAB);
    chk("mem_21", mem[10'h021], 8'h12);
    chk("mem_alias0", {mem[10'h001], mem[10'h000]}, 16'h0000);

    // ---------------- reset during SB in WRITE ----------------
    model(SW, 16'h0030, 16'h1234, 3'd0, exp);
    run_req(SW, 16'h0030, 16'h1234, 3'd0, 0, got);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = SB; bus.req_addr = 16'h0030;
    bus.req_wdata = 16'h00CD; bus.req_rd = 3'd5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rmw_access_state", state_dbg, 2'd1);
    chk("rmw_access_we", bus.mem_we, 1'b0);
    @(negedge clk);
    chk("rmw_write_state", state_dbg, 2'd2);
    chk("rmw_write_we", bus.mem_we, 1'b1);
    chk("rmw_write_data", bus.mem_wdata, 16'h12CD);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    chk("rst_mid_state", state_dbg, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", bus.req_ready, 1'b1);
    chk("rst_rel_busy", bus.busy, 1'b0);
    chk("rst_mem_kept", {mem[10'h031], mem[10'h030]}, 16'h1234);

    // ---------------- zero-extending LB ----------------
    for (int k = 0; k < 2; k++) begin
      logic [15:0] word;
      logic [15:0] want;
      word = (k == 0) ? 16'h12AB : 16'h7F80;
      want = {8'h00, word[7:0]};
      zx_rdata = word;
      @(negedge clk);
      zbus.req_valid = 1'b1; zbus.req_op = LB; zbus.req_addr = 16'h0020; zbus.req_rd = 3'd2;
      @(negedge clk);
      zbus.req_valid = 1'b0;
      chk("zx_no_we", zbus.mem_we, 1'b0);
      @(negedge clk);
      chk("zx_valid", zbus.resp_valid, 1'b1);
      chk("zx_data", zbus.resp_data, want);
      chk("zx_wen", zbus.resp_wen, 1'b1);
      zbus.resp_ready = 1'b1;
      @(negedge clk);
      zbus.resp_ready = 1'b0;
      chk("zx_idle", zbus.busy, 1'b0);
    end

    // ---------------- randomized against the model ----------------
    for (int n = 0; n < 200; n++) begin
      logic [1:0]      op;
      logic [15:0]     addr;
      logic [15:0]     wdata;
      logic [RD_W-1:0] rd;
      int              sel;
      int              stall;
      op    = 2'($urandom_range(0, 3));
      sel   = $urandom_range(0, 9);
      if (sel < 6)       addr = 16'($urandom_range(0, 63));
      else if (sel < 8)  addr = 16'($urandom_range(0, 16'h03FE));
      else if (sel == 8) addr = LIMIT + 16'($urandom_range(0, 1));
      else               addr = 16'($urandom_range(16'h03FF, 16'hFFFF));
      wdata = 16'($urandom);
      rd    = RD_W'($urandom);
      stall = $urandom_range(0, 3);
      model(op, addr, wdata, rd, exp);
      run_req(op, addr, wdata, rd, stall, got);
      cmp_resp("rand", got, exp);
    end

    mism = 0;
    for (int a = 0; a < 1024; a++) begin
      if (mem[a] !== ref_mem[a]) mism++;
    end
    chk("mem_image_mismatches", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
